instruction_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of instruction_decoder and ControlUnit. It owns the PC and issues one-outstanding-request reads to instruction memory. It holds fetched words in an IF/ID output register plus a one-entry skid buffer, and presents the decoded field slices (opcode, rs, rt, rd, imm) that the decode stage consumes. It handles decode back-pressure (stall) and branch redirect/flush.

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_skid_buffer.sv | 33 +++
 rtl/instruction_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions: instruction field positions and fetch FSM encoding.
package instruction_fetch_unit_pkg;

  localparam int INSTR_WIDTH = 32;

  // Field MSB positions inside an instruction word
  localparam int OPC_MSB = 31;
  localparam int RS_MSB  = 25;
  localparam int RT_MSB  = 20;
  localparam int RD_MSB  = 15;
  localparam int IMM_MSB = 15;

  // Fetch FSM: issue request, wait for the single outstanding response,
  // or hold a word in the skid buffer while decode is stalled.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_skid_buffer.sv
// One-entry holding register for a fetched word and its address, used when
// the response arrives while the IF/ID register is blocked by decode.
module fetch_skid_buffer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   unload,
  input  logic                   clear,
  input  logic [31:0]            instr_in,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic                   valid,
  output logic [31:0]            instr,
  output logic [ADDR_WIDTH-1:0]  pc
);

  // Clear/unload win over load so a redirect never leaves a stale entry
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear || unload) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, and presents the IF/ID register plus decoded field
// slices to decode. Handles decode stall (via a skid entry) and redirects.
//
// Memory handshake: imem_req is a request valid; a request is accepted on
// the cycle imem_gnt is high while imem_req is high. The response arrives as
// a single imem_rvalid pulse on a later cycle, and only while in S_WAIT.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  input  logic                   id_stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   if_id_valid,
  output logic [31:0]            if_id_instr,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [ADDR_WIDTH-1:0]  if_id_pc_plus4,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [15:0]            imm
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  discard;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic                  out_free;
  logic                  skid_load;
  logic                  skid_unload;
  logic                  skid_valid;
  logic [31:0]           skid_instr;
  logic [ADDR_WIDTH-1:0] skid_pc;

  assign target_aligned = branch_target & ALIGN_MASK;
  assign out_free       = !if_id_valid || !id_stall;

  // Request is suppressed combinationally during reset so no fetch leaks out
  assign imem_req  = (state == S_REQ) && !reset;
  assign imem_addr = pc;

  // Blocked response goes to the skid; skid drains when decode frees up
  assign skid_load   = !branch_taken && (state == S_WAIT) && imem_rvalid &&
                       !discard && !out_free;
  assign skid_unload = !branch_taken && (state == S_FULL) && !id_stall;

  fetch_skid_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (branch_taken),
    .instr_in (imem_rdata),
    .pc_in    (req_pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // Fetch FSM together with PC and IF/ID register updates
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      req_pc         <= '0;
      discard        <= 1'b0;
      if_id_valid    <= 1'b0;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
    end else if (branch_taken) begin
      pc          <= target_aligned;
      if_id_valid <= 1'b0;
      case (state)
        S_REQ: begin
          // A request accepted this cycle is already stale: drop its response
          if (imem_gnt) begin
            state   <= S_WAIT;
            discard <= 1'b1;
          end else begin
            state <= S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state   <= S_REQ;
            discard <= 1'b0;
          end else begin
            state   <= S_WAIT;
            discard <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      // Bubble when decode consumed the word and nothing new arrives
      if (!id_stall) begin
        if_id_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            state  <= S_WAIT;
            req_pc <= pc;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else if (out_free) begin
              if_id_valid    <= 1'b1;
              if_id_instr    <= imem_rdata;
              if_id_pc       <= req_pc;
              if_id_pc_plus4 <= req_pc + PC_STEP;
              pc             <= req_pc + PC_STEP;
              state          <= S_REQ;
            end else begin
              pc    <= req_pc + PC_STEP;
              state <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!id_stall) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= skid_instr;
            if_id_pc       <= skid_pc;
            if_id_pc_plus4 <= skid_pc + PC_STEP;
            state          <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign opcode = if_id_instr[OPC_MSB -: 6];
  assign rs     = if_id_instr[RS_MSB  -: 5];
  assign rt     = if_id_instr[RT_MSB  -: 5];
  assign rd     = if_id_instr[RD_MSB  -: 5];
  assign imm    = if_id_instr[IMM_MSB -: 16];

`ifndef SYNTHESIS
  // A response outside S_WAIT means the memory broke the one-outstanding rule
  rvalid_only_in_wait: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (state == S_WAIT));

  // S_FULL is only reachable with a word parked in the skid
  skid_live_in_full: assert property (@(posedge clk) disable iff (reset)
    (state == S_FULL) |-> skid_valid);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit. Each table row is
// one clock cycle: the inputs applied in that cycle and the outputs expected
// to be visible during that same cycle (before its rising edge).
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .imm            (imm)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
    end
  endtask

  task automatic row(input logic rst, input logic gnt, input logic rv,
                     input logic [31:0] rdata, input logic stall, input logic br,
                     input logic [31:0] tgt, input logic e_req,
                     input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic [31:0] e_pc4);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.stall = stall;
    v.br = br; v.tgt = tgt; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc4 = e_pc4;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] W0   = 32'h0422_0005; // op 1, rs 1, rt 2, imm 5
  localparam logic [31:0] W4   = 32'h8C43_0010; // op 0x23, rs 2, rt 3, imm 0x10
  localparam logic [31:0] W8   = 32'h0085_1820; // op 0, rs 4, rt 5, rd 3
  localparam logic [31:0] W12  = 32'hDEAD_BEEF; // stale, must be discarded
  localparam logic [31:0] W100 = 32'h3C01_ABCD; // op 0x0F, rt 1, imm 0xABCD
  localparam logic [31:0] WJNK = 32'h1111_1111; // stale, must be discarded
  localparam logic [31:0] WFC  = 32'h2402_FFFF; // op 9, rt 2, imm 0xFFFF
  localparam logic [31:0] WRST = 32'h5555_5555; // arrives during reset
  localparam logic [31:0] WAC  = 32'hAC64_0008; // op 0x2B, rs 3, rt 4, imm 8

  initial begin
    vec_t v;
    logic [31:0] ei;
    checks = 0;
    errors = 0;

    //   rst gnt rv rdata stall br tgt          req addr         valid instr pc           pc4
    for (int i = 0; i < 4; i++)
      row(1, 0, 0, 0, 0, 0, 0,                  0, 32'h0,        0, 32'h0, 32'h0,       32'h0);
    // Streaming from RESET_PC
    row(0, 1, 0, 0,    0, 0, 0,                 1, 32'h0,        0, 32'h0, 32'h0,       32'h0);
    row(0, 0, 1, W0,   0, 0, 0,                 0, 32'h0,        0, 32'h0, 32'h0,       32'h0);
    row(0, 1, 0, 0,    0, 0, 0,                 1, 32'h4,        1, W0,    32'h0,       32'h4);
    row(0, 0, 1, W4,   0, 0, 0,                 0, 32'h4,        0, W0,    32'h0,       32'h4);
    // Stall while the addr 8 word returns: it parks in the skid
    row(0, 1, 0, 0,    1, 0, 0,                 1, 32'h8,        1, W4,    32'h4,       32'h8);
    row(0, 0, 1, W8,   1, 0, 0,                 0, 32'h8,        1, W4,    32'h4,       32'h8);
    for (int i = 0; i < 4; i++)
      row(0, 0, 0, 0,  1, 0, 0,                 0, 32'hC,        1, W4,    32'h4,       32'h8);
    row(0, 0, 0, 0,    0, 0, 0,                 0, 32'hC,        1, W4,    32'h4,       32'h8);
    row(0, 1, 0, 0,    1, 0, 0,                 1, 32'hC,        1, W8,    32'h8,       32'hC);
    // Redirect while waiting for addr 12 (also overrides the stall)
    row(0, 0, 0, 0,    1, 1, 32'h103,           0, 32'hC,        1, W8,    32'h8,       32'hC);
    row(0, 0, 1, W12,  0, 0, 0,                 0, 32'h100,      0, W8,    32'h8,       32'hC);
    row(0, 0, 0, 0,    0, 0, 0,                 1, 32'h100,      0, W8,    32'h8,       32'hC);
    row(0, 1, 0, 0,    0, 0, 0,                 1, 32'h100,      0, W8,    32'h8,       32'hC);
    row(0, 0, 1, W100, 0, 0, 0,                 0, 32'h100,      0, W8,    32'h8,       32'hC);
    // Redirect in S_REQ on the same cycle as gnt, target unaligned
    row(0, 1, 0, 0,    0, 1, 32'hFFFF_FFFE,     1, 32'h104,      1, W100,  32'h100,     32'h104);
    row(0, 0, 1, WJNK, 0, 0, 0,                 0, 32'hFFFF_FFFC,0, W100,  32'h100,     32'h104);
    row(0, 1, 0, 0,    0, 0, 0,                 1, 32'hFFFF_FFFC,0, W100,  32'h100,     32'h104);
    row(0, 0, 1, WFC,  0, 0, 0,                 0, 32'hFFFF_FFFC,0, W100,  32'h100,     32'h104);
    // Wrap: pc_plus4 and next fetch address roll over to 0
    row(0, 0, 0, 0,    0, 0, 0,                 1, 32'h0,        1, WFC,   32'hFFFF_FFFC,32'h0);
    // Redirect in S_REQ without gnt: address switches next cycle
    row(0, 0, 0, 0,    0, 1, 32'h40,            1, 32'h0,        0, WFC,   32'hFFFF_FFFC,32'h0);
    row(0, 1, 0, 0,    0, 0, 0,                 1, 32'h40,       0, WFC,   32'hFFFF_FFFC,32'h0);
    // Reset while waiting; response lands during reset and is ignored
    row(1, 0, 1, WRST, 0, 0, 0,                 0, 32'h40,       0, WFC,   32'hFFFF_FFFC,32'h0);
    row(1, 0, 0, 0,    0, 0, 0,                 0, 32'h0,        0, 32'h0, 32'h0,       32'h0);
    // Empty IF/ID accepts a word even with stall high
    row(0, 1, 0, 0,    1, 0, 0,                 1, 32'h0,        0, 32'h0, 32'h0,       32'h0);
    row(0, 0, 1, WAC,  1, 0, 0,                 0, 32'h0,        0, 32'h0, 32'h0,       32'h0);
    row(0, 0, 0, 0,    1, 0, 0,                 1, 32'h4,        1, WAC,   32'h0,       32'h4);

    // Preamble: one reset edge so the first table row sees defined state
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      reset = v.rst; imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata;
      id_stall = v.stall; branch_taken = v.br; branch_target = v.tgt;
      #1;
      check("imem_req",       i, {31'b0, imem_req},    {31'b0, v.e_req});
      check("imem_addr",      i, imem_addr,            v.e_addr);
      check("if_id_valid",    i, {31'b0, if_id_valid}, {31'b0, v.e_valid});
      check("if_id_instr",    i, if_id_instr,          v.e_instr);
      check("if_id_pc",       i, if_id_pc,             v.e_pc);
      check("if_id_pc_plus4", i, if_id_pc_plus4,       v.e_pc4);
      ei = v.e_instr;
      check("opcode", i, {26'b0, opcode}, {26'b0, ei[31:26]});
      check("rs",     i, {27'b0, rs},     {27'b0, ei[25:21]});
      check("rt",     i, {27'b0, rt},     {27'b0, ei[20:16]});
      check("rd",     i, {27'b0, rd},     {27'b0, ei[15:11]});
      check("imm",    i, {16'b0, imm},    {16'b0, ei[15:0]});
      // Hand-decoded fields for the first streamed word
      if (i == 6) begin
        check("w0_opcode", i, {26'b0, opcode}, 32'd1);
        check("w0_rs",     i, {27'b0, rs},     32'd1);
        check("w0_rt",     i, {27'b0, rt},     32'd2);
        check("w0_imm",    i, {16'b0, imm},    32'd5);
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
